// File: rtl/mmio_timer_pkg.sv
// Shared constants for the memory-mapped machine timer: register offsets,
// CTRL/STATUS bit positions, the compare reset value and a byte-lane merge helper.
package mmio_timer_pkg;

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_STATUS   = 3'd5;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STATUS_PEND = 0;

    localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] applyBytes(input logic [31:0] oldVal,
                                               input logic [31:0] wrData,
                                               input logic [3:0]  byteEn);
        logic [31:0] res;
        res = oldVal;
        for (int i = 0; i < 4; i++)
            if (byteEn[i]) res[8*i +: 8] = wrData[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// Core data-bus port as seen by the timer: read/write strobes, byte lanes,
// address, write data and the OR-able read data return.
interface mmio_timer_if;
    logic        DwReadEnable;
    logic        DwWriteEnable;
    logic [3:0]  DwByteEnable;
    logic [31:0] DwAddress;
    logic [31:0] DwWriteData;
    logic [31:0] DwReadData;

    modport master (output DwReadEnable, DwWriteEnable, DwByteEnable, DwAddress, DwWriteData,
                    input  DwReadData);
    modport slave  (input  DwReadEnable, DwWriteEnable, DwByteEnable, DwAddress, DwWriteData,
                    output DwReadData);
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Tick divider: counts 0..PRESCALE-1 while enabled, holds while disabled,
// and pulses tick for one cycle on the wrap.
module mmio_timer_prescaler #(
    parameter int unsigned PRESCALE = 50
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic enable,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + 16'd1;
    end
endmodule

// File: rtl/mmio_timer.sv
// Machine timer on the core data bus: 64-bit mtime/compare, level IRQ.
// MMIO_TIMER_PRESCALER_EN selects one tick per PRESCALE cycles instead of every cycle.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFF20_0500,
    parameter int unsigned PRESCALE  = 50
) (
    input  logic         iCLK,
    input  logic         iRST,
    mmio_timer_if.slave  bus,
    output logic         oIRQ
);
    logic [63:0] mtime, mtimeInc, cmp;
    logic [31:0] shadow;
    logic [1:0]  ctrl;
    logic        pend, tick, en, match;
    logic        sel, wrEn, rdEn;
    logic [2:0]  off;
    logic        unusedAddr;

    assign sel        = (bus.DwAddress[31:5] == BASE_ADDR[31:5]);
    assign off        = bus.DwAddress[4:2];
    assign unusedAddr = ^bus.DwAddress[1:0];
    assign wrEn       = bus.DwWriteEnable & sel;
    assign rdEn       = bus.DwReadEnable & sel;
    assign en         = ctrl[CTRL_EN];

`ifdef MMIO_TIMER_PRESCALER_EN
    mmio_timer_prescaler #(.PRESCALE(PRESCALE)) uPrescaler (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .enable (en),
        .tick   (tick)
    );
`else
    assign tick = en;
`endif

    // Full 64-bit increment first; a CPU write then overlays only its own bytes.
    assign mtimeInc = mtime + 64'(tick);
    assign match    = en && (mtime >= cmp);
    assign oIRQ     = pend & ctrl[CTRL_IRQ_EN];

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            mtime  <= '0;
            cmp    <= CMP_RESET;
            ctrl   <= '0;
            shadow <= '0;
            pend   <= 1'b0;
        end else begin
            mtime[31:0]  <= (wrEn && off == OFF_MTIME_LO)
                            ? applyBytes(mtimeInc[31:0], bus.DwWriteData, bus.DwByteEnable)
                            : mtimeInc[31:0];
            mtime[63:32] <= (wrEn && off == OFF_MTIME_HI)
                            ? applyBytes(mtimeInc[63:32], bus.DwWriteData, bus.DwByteEnable)
                            : mtimeInc[63:32];
            if (wrEn && off == OFF_CMP_LO)
                cmp[31:0]  <= applyBytes(cmp[31:0], bus.DwWriteData, bus.DwByteEnable);
            if (wrEn && off == OFF_CMP_HI)
                cmp[63:32] <= applyBytes(cmp[63:32], bus.DwWriteData, bus.DwByteEnable);
            if (wrEn && off == OFF_CTRL && bus.DwByteEnable[0])
                ctrl <= bus.DwWriteData[1:0];
            if (rdEn && off == OFF_MTIME_LO)
                shadow <= mtime[63:32];
            // Set beats W1C when both land in the same cycle.
            if (match)
                pend <= 1'b1;
            else if (wrEn && off == OFF_STATUS && bus.DwByteEnable[0] && bus.DwWriteData[STATUS_PEND])
                pend <= 1'b0;
        end
    end

    always_comb begin
        bus.DwReadData = '0;
        if (sel) begin
            case (off)
                OFF_MTIME_LO: bus.DwReadData = mtime[31:0];
                OFF_MTIME_HI: bus.DwReadData = shadow;
                OFF_CMP_LO:   bus.DwReadData = cmp[31:0];
                OFF_CMP_HI:   bus.DwReadData = cmp[63:32];
                OFF_CTRL:     bus.DwReadData = {30'd0, ctrl};
                OFF_STATUS:   bus.DwReadData = {31'd0, pend};
                default:      bus.DwReadData = '0;
            endcase
        end
    end
endmodule
